dot_feeder_23: RTL and testbench
================================

# dot_feeder_23

Sequencer that drives one `dot_channel_23` from the producer side. It assembles a 36-word activation vector from a serial input stream and holds it on `d`. It then walks every chip-select/phase combination, issuing `ws_load`/`dc_load`, waiting for the channel's `valid`, and forwarding each channel result as a one-cycle output beat. It sits between the activation line buffer and the dot channel.

## Interface
- `CS_NUM`, default 9: number of chip-select values per phase, walked 0..CS_NUM-1. Legal range 1..16.
- `PHASE_NUM`, default 8: number of phases, walked 0..PHASE_NUM-1. Legal range 1..8.
- `TIMEOUT`, default 15: maximum number of WAIT cycles tolerated without `dc_valid`.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  begins a run; sampled only in IDLE.
- `in_valid`  in  1  serial activation word is valid.
- `in_data`  in  `data_len`  serial activation word (`data_len` comes from `num_data.v`).
- `in_ready`  out  1  high only in FILL.
- `d`  out  36*`data_len`  assembled vector to the channel; word k occupies bits [k*data_len +: data_len].
- `cs`  out  4  current chip-select.
- `phase`  out  3  current phase.
- `ws_load`  out  1  weight-store load to the channel.
- `dc_load`  out  1  inner-product load to the channel.
- `dc_valid`  in  1  channel `valid`.
- `dc_q`  in  `data_len`  channel `q`.
- `out_valid`  out  1  one-cycle pulse; `out_data` is valid.
- `out_data`  out  `data_len`  captured channel result.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at the end of a successful run.
- `err`  out  1  one-cycle pulse on a watchdog abort.

## Operation
- The FSM has five states: IDLE, FILL, LOAD, WAIT, GAP.
- IDLE
  - `start` moves the FSM to FILL.
  - On that transition `cs` and `phase` are cleared to 0 and `fill_cnt` is cleared to 0.
- FILL
  - `in_ready` is 1.
  - Each beat with `in_valid` high writes `in_data` into word `fill_cnt` of `d`, then increments `fill_cnt`.
  - The 36th accepted beat moves the FSM to LOAD.
  - `d` is never cleared between phases; every word is overwritten.
- LOAD (one cycle)
  - `ws_load` and `dc_load` are raised. The FSM moves to WAIT.
- WAIT
  - `ws_load` and `dc_load` stay high. `d`, `cs` and `phase` are held stable.
  - When `dc_valid` = 1:
    - `dc_q` is registered into `out_data`.
    - `out_valid` pulses on the next cycle.
    - The FSM moves to GAP.
  - `wd_cnt` counts WAIT cycles. If it reaches `TIMEOUT` without `dc_valid`:
    - `err` pulses.
    - `ws_load` and `dc_load` drop.
    - The FSM moves to IDLE; `done` is not pulsed.
- GAP (one cycle)
  - `ws_load` and `dc_load` are 0, so the channel clears its internal counter and `valid`.
  - If `cs` < CS_NUM-1: `cs` increments and the FSM moves to LOAD.
  - Otherwise `cs` wraps to 0:
    - If `phase` < PHASE_NUM-1: `phase` increments, `fill_cnt` is cleared, and the FSM moves to FILL so a new vector is loaded for the new phase.
    - Otherwise `done` pulses and the FSM moves to IDLE.
- `dc_valid` is ignored outside WAIT.
- `start` is ignored outside IDLE.
- `in_valid` is ignored outside FILL.

## Timing
- Reset values: `in_ready`, `ws_load`, `dc_load`, `out_valid`, `busy`, `done` and `err` are 0; `cs`, `phase`, `d` and `out_data` are 0; the state is IDLE.
- Reset mid-run takes effect on the same edge: any in-flight result is dropped and no `out_valid`, `done` or `err` is issued.
- `start` at edge t:
  - `busy` and `in_ready` are 1 from t+1.
  - With `in_valid` held high continuously, the 36th word is accepted at edge t+36.
  - LOAD is active in cycle t+37, with `ws_load` and `dc_load` visible from t+37.
- With the channel's 3-deep counter, `dc_valid` rises 4 cycles after the first `dc_load` cycle.
- `out_valid` follows the `dc_valid` cycle by 1. GAP follows in the same cycle as `out_valid`.
- `ws_load`/`dc_load` low time between consecutive cs values is exactly 1 cycle.
- `done` pulses in the cycle after the last GAP; `busy` drops in the same cycle.
- `out_valid` is produced exactly CS_NUM*PHASE_NUM times per successful run, ordered phase-major, cs-minor.
- If `dc_valid` arrives in the same cycle that the watchdog would expire, the result is accepted and `err` is not pulsed.
- Edge cases:
  - CS_NUM = 1: every GAP takes the wrap branch.
  - PHASE_NUM = 1: the run ends after a single fill.

## Test plan
- Reset, then idle 5 cycles -> all outputs 0 and `in_ready` = 0.
- CS_NUM = 2, PHASE_NUM = 1, `in_data` = k for word k, and a channel model returning `dc_q` = 0x10+cs after 4 cycles:
  - `d` word 5 = 5.
  - `out_data` sequence is 0x10, 0x11.
  - `done` pulses once; exactly one GAP cycle precedes cs = 1.
- FILL with `in_valid` toggled every other cycle -> 72 cycles to fill; `d` is correct; `in_ready` stays high throughout FILL.
- CS_NUM = 9, PHASE_NUM = 8, full run:
  - 72 `out_valid` pulses.
  - 8 FILL periods.
  - `phase` reaches 7 and `cs` wraps from 8 to 0.
- `dc_valid` withheld, TIMEOUT = 15 -> `err` pulses after 15 WAIT cycles; no `done`; next `start` runs normally.
- `rst` asserted during WAIT at phase 3 -> next edge: IDLE, `ws_load`/`dc_load` = 0, no `out_valid`; a stray `start` during the run is ignored.

Source files
------------

// File: rtl/dot_feeder_23.sv
// ============================================================================
// Module   : dot_feeder_23
// Purpose  : Producer-side sequencer for one dot channel: fills a 36-word
//            activation vector, then walks every phase/chip-select pair.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dot_feeder_23 #(
    parameter int DATA_LEN  = 16,
    parameter int CS_NUM    = 9,
    parameter int PHASE_NUM = 8,
    parameter int TIMEOUT   = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic                     i_in_valid,
    input  logic [DATA_LEN-1:0]      i_in_data,
    output logic                     o_in_ready,
    output logic [36*DATA_LEN-1:0]   o_d,
    output logic [3:0]               o_cs,
    output logic [2:0]               o_phase,
    output logic                     o_ws_load,
    output logic                     o_dc_load,
    input  logic                     i_dc_valid,
    input  logic [DATA_LEN-1:0]      i_dc_q,
    output logic                     o_out_valid,
    output logic [DATA_LEN-1:0]      o_out_data,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err
);

    localparam int              c_NUM_WORDS = 36;
    localparam int              c_WD_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);
    localparam logic [3:0]      c_CS_LAST   = 4'(CS_NUM - 1);
    localparam logic [2:0]      c_PH_LAST   = 3'(PHASE_NUM - 1);
    localparam logic [5:0]      c_FILL_LAST = 6'(c_NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FILL = 3'd1,
        S_LOAD = 3'd2,
        S_WAIT = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    state_t                       r_state;
    logic [5:0]                   r_fill_cnt;
    logic [c_WD_W-1:0]            r_wd_cnt;
    logic [c_NUM_WORDS*DATA_LEN-1:0] r_d;
    logic [3:0]                   r_cs;
    logic [2:0]                   r_phase;
    logic                         r_in_ready;
    logic                         r_ws_load;
    logic                         r_dc_load;
    logic                         r_out_valid;
    logic [DATA_LEN-1:0]          r_out_data;
    logic                         r_busy;
    logic                         r_done;
    logic                         r_err;

    // Outputs are registered alongside each transition so they line up with the new state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_fill_cnt  <= '0;
            r_wd_cnt    <= '0;
            r_d         <= '0;
            r_cs        <= '0;
            r_phase     <= '0;
            r_in_ready  <= 1'b0;
            r_ws_load   <= 1'b0;
            r_dc_load   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state    <= S_FILL;
                        r_cs       <= '0;
                        r_phase    <= '0;
                        r_fill_cnt <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_FILL: begin
                    if (i_in_valid) begin
                        for (int k = 0; k < c_NUM_WORDS; k++) begin
                            if (r_fill_cnt == 6'(k)) begin
                                r_d[k*DATA_LEN +: DATA_LEN] <= i_in_data;
                            end
                        end
                        r_fill_cnt <= r_fill_cnt + 6'd1;
                        if (r_fill_cnt == c_FILL_LAST) begin
                            r_state    <= S_LOAD;
                            r_in_ready <= 1'b0;
                            r_ws_load  <= 1'b1;
                            r_dc_load  <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    r_state  <= S_WAIT;
                    r_wd_cnt <= '0;
                end
                S_WAIT: begin
                    // A result arriving on the last tolerated cycle still wins over the watchdog.
                    if (i_dc_valid) begin
                        r_out_data  <= i_dc_q;
                        r_out_valid <= 1'b1;
                        r_ws_load   <= 1'b0;
                        r_dc_load   <= 1'b0;
                        r_state     <= S_GAP;
                    end else if (r_wd_cnt == c_WD_LAST) begin
                        r_err     <= 1'b1;
                        r_ws_load <= 1'b0;
                        r_dc_load <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_cs < c_CS_LAST) begin
                        r_cs      <= r_cs + 4'd1;
                        r_ws_load <= 1'b1;
                        r_dc_load <= 1'b1;
                        r_state   <= S_LOAD;
                    end else begin
                        r_cs <= '0;
                        if (r_phase < c_PH_LAST) begin
                            r_phase    <= r_phase + 3'd1;
                            r_fill_cnt <= '0;
                            r_in_ready <= 1'b1;
                            r_state    <= S_FILL;
                        end else begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_d         = r_d;
    assign o_cs        = r_cs;
    assign o_phase     = r_phase;
    assign o_ws_load   = r_ws_load;
    assign o_dc_load   = r_dc_load;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_dot_feeder_23.sv
// ============================================================================
// Module   : tb_dot_feeder_23
// Purpose  : Self-checking bench for dot_feeder_23 with a latency-programmable
//            dot-channel model and random activation data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dot_feeder_23;

    localparam int DL  = 16;
    localparam int CSN = 9;
    localparam int PN  = 8;
    localparam int TO  = 15;
    localparam int NW  = 36;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_start;
    logic             i_in_valid;
    logic [DL-1:0]    i_in_data;
    logic             o_in_ready;
    logic [NW*DL-1:0] o_d;
    logic [3:0]       o_cs;
    logic [2:0]       o_phase;
    logic             o_ws_load;
    logic             o_dc_load;
    logic             i_dc_valid;
    logic [DL-1:0]    i_dc_q;
    logic             o_out_valid;
    logic [DL-1:0]    o_out_data;
    logic             o_busy;
    logic             o_done;
    logic             o_err;

    int               total = 0;
    int               bad   = 0;
    int               lat   = 4;
    int               ch_cnt = 0;
    logic [DL-1:0]    salt  = '0;
    logic [NW*DL-1:0] exp_d = '0;

    int               ov_cnt = 0;
    int               done_cnt = 0;
    int               err_cnt = 0;
    int               fill_rises = 0;
    logic             rdy_q = 1'b0;

    always #5 clk = ~clk;

    dot_feeder_23 #(
        .DATA_LEN  (DL),
        .CS_NUM    (CSN),
        .PHASE_NUM (PN),
        .TIMEOUT   (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_in_valid  (i_in_valid),
        .i_in_data   (i_in_data),
        .o_in_ready  (o_in_ready),
        .o_d         (o_d),
        .o_cs        (o_cs),
        .o_phase     (o_phase),
        .o_ws_load   (o_ws_load),
        .o_dc_load   (o_dc_load),
        .i_dc_valid  (i_dc_valid),
        .i_dc_q      (i_dc_q),
        .o_out_valid (o_out_valid),
        .o_out_data  (o_out_data),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    // Channel: result becomes valid after `lat` consecutive load cycles; clears when load drops.
    always @(posedge clk) begin
        if (!o_dc_load) ch_cnt <= 0;
        else if (ch_cnt < 100) ch_cnt <= ch_cnt + 1;
    end
    assign i_dc_valid = o_dc_load && (ch_cnt >= lat);
    assign i_dc_q     = salt + DL'(o_phase * 16 + o_cs);

    always @(posedge clk) begin
        if (o_out_valid) ov_cnt <= ov_cnt + 1;
        if (o_done) done_cnt <= done_cnt + 1;
        if (o_err) err_cnt <= err_cnt + 1;
        if (o_in_ready && !rdy_q) fill_rises <= fill_rises + 1;
        rdy_q <= o_in_ready;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [NW*DL-1:0] exp);
        total++;
        assert (o_d === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o_d, exp);
        end
    endtask

    task automatic kick();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("start_busy", {o_busy, o_in_ready}, 2'b11);
    endtask

    task automatic fill(input int mode, input int p);
        logic [DL-1:0] w;
        int acc;
        int cyc;
        acc = 0;
        cyc = 0;
        while (acc < NW && cyc < 300) begin
            w = DL'($urandom);
            case (mode)
                0:       i_in_valid = 1'b1;
                1:       i_in_valid = cyc[0];
                default: i_in_valid = 1'($urandom_range(0, 1));
            endcase
            i_in_data = w;
            i_start   = (p == 1 && acc == 10);
            chk("fill_ready", o_in_ready, 1);
            @(posedge clk);
            if (i_in_valid) begin
                exp_d[acc*DL +: DL] = w;
                acc++;
            end
            cyc++;
            @(negedge clk);
        end
        i_in_valid = 1'b0;
        i_in_data  = '0;
        i_start    = 1'b0;
        if (mode == 1) chk("fill_cycles", cyc, 2 * NW);
        chk("load_loads", {o_ws_load, o_dc_load, o_in_ready}, 3'b110);
        chk("load_sel", {o_phase, o_cs}, {3'(p), 4'd0});
        chk_vec("load_d", exp_d);
    endtask

    task automatic run(input int mode, input int abort_p);
        int ov0, dn0, fr0, er0, k;
        ov0  = ov_cnt;
        dn0  = done_cnt;
        fr0  = fill_rises;
        er0  = err_cnt;
        salt = DL'($urandom);
        kick();
        for (int p = 0; p < PN; p++) begin
            fill(mode, p);
            if (p == abort_p) begin
                repeat (lat) @(negedge clk);
                chk("abort_phase", o_phase, 3'(p));
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("abort_idle", {o_busy, o_in_ready, o_ws_load, o_dc_load, o_out_valid, o_done, o_err}, 0);
                chk("abort_sel", {o_phase, o_cs}, 0);
                chk_vec("abort_d", '0);
                @(negedge clk);
                chk("abort_no_ov", o_out_valid, 0);
                chk("abort_ov_count", ov_cnt - ov0, p * CSN);
                chk("abort_no_done", done_cnt - dn0, 0);
                return;
            end
            for (int c = 0; c < CSN; c++) begin
                k = 0;
                while (!o_out_valid && k < 40) begin
                    @(negedge clk);
                    k++;
                end
                chk("ov_seen", o_out_valid, 1);
                chk("ov_latency", k, lat + 1);
                chk("out_data", o_out_data, salt + DL'(p * 16 + c));
                chk("gap_sel", {o_phase, o_cs}, {3'(p), 4'(c)});
                chk("gap_loads", {o_ws_load, o_dc_load}, 0);
                @(negedge clk);
                if (c < CSN - 1)
                    chk("next_load", {o_ws_load, o_dc_load, o_cs}, {2'b11, 4'(c + 1)});
                else if (p < PN - 1)
                    chk("refill", {o_in_ready, o_busy, o_phase, o_cs}, {2'b11, 3'(p + 1), 4'd0});
                else
                    chk("done_pulse", {o_done, o_busy, o_cs}, {2'b10, 4'd0});
            end
        end
        @(negedge clk);
        chk("done_once", o_done, 0);
        chk("ov_count", ov_cnt - ov0, CSN * PN);
        chk("done_count", done_cnt - dn0, 1);
        chk("fill_periods", fill_rises - fr0, PN);
        chk("no_err", err_cnt - er0, 0);
    endtask

    initial begin
        int k;
        int d0;
        rst        = 1'b1;
        i_start    = 1'b0;
        i_in_valid = 1'b0;
        i_in_data  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_ctrl", {o_in_ready, o_ws_load, o_dc_load, o_out_valid, o_busy, o_done, o_err}, 0);
        chk("rst_sel", {o_phase, o_cs}, 0);
        chk("rst_out_data", o_out_data, 0);
        chk_vec("rst_d", '0);

        run(0, -1);

        // Withheld result: watchdog expires after TIMEOUT wait cycles.
        lat = 16;
        d0  = done_cnt;
        kick();
        fill(0, 0);
        k = 0;
        while (!o_err && k < 40) begin
            if (k == TO) chk("wd_last_wait", {o_ws_load, o_dc_load, o_busy}, 3'b111);
            @(negedge clk);
            k++;
        end
        chk("wd_err", o_err, 1);
        chk("wd_cycles", k, TO + 1);
        chk("wd_idle", {o_busy, o_ws_load, o_dc_load, o_out_valid, o_done}, 0);
        @(negedge clk);
        chk("wd_err_pulse", o_err, 0);
        chk("wd_no_done", done_cnt - d0, 0);

        // Result on the final tolerated wait cycle is accepted.
        lat  = TO;
        salt = DL'($urandom);
        kick();
        fill(0, 0);
        k = 0;
        while (!o_out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("edge_ov", o_out_valid, 1);
        chk("edge_latency", k, TO + 1);
        chk("edge_no_err", o_err, 0);
        chk("edge_data", o_out_data, salt);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        lat = 4;

        run(1, -1);
        run(2, 3);
        run(2, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

endmodule

`default_nettype wire
